// File: rtl/uart_tx_if.sv
// Handshake bundle between the data producer and uart_tx.
// The producer uses the master modport; the transmitter uses the slave modport.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_ready,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_ready,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, DATA_BITS LSB-first, optional even parity, one stop bit.
// Defining UART_TX_PARITY_EN compiles in the PARITY state.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic        clk,
    input  logic        reset,
    uart_tx_if.slave    tx,
    output logic        tx_serial
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    // serial_d always carries the level of the bit the next state will drive,
    // so the line is registered yet aligned with the state register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                if (tx.tx_start) begin
                    shift_d  = tx.tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx.tx_data;
`endif
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = S_START;
                    serial_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = S_PARITY;
                        serial_d = parity_q;
`else
                        state_d  = S_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        serial_d = shift_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = S_STOP;
                    serial_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                    serial_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d    = '0;
                idx_d    = '0;
                state_d  = S_IDLE;
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx.tx_ready = (state_q == S_IDLE);
    assign tx.tx_busy  = (state_q != S_IDLE);
    assign tx.tx_done  = done_q;
    assign tx_serial   = serial_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast N=4 instance and a default N=434 instance
// fed from the same stimulus.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data;
    logic       s_serial;
    logic       b_serial;
    int         total = 0;
    int         bad   = 0;

`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif

    uart_tx_if #(.DATA_BITS(8)) sif ();
    uart_tx_if #(.DATA_BITS(8)) bif ();

    assign sif.tx_start = start;
    assign sif.tx_data  = data;
    assign bif.tx_start = start;
    assign bif.tx_data  = data;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .tx        (sif.slave),
        .tx_serial (s_serial)
    );

    uart_tx dut_big (
        .clk       (clk),
        .reset     (reset),
        .tx        (bif.slave),
        .tx_serial (b_serial)
    );

    always #5 clk = ~clk;

    // Caller sets start/data during cycle 0; checks cycles 1 .. F*n+1.
    task automatic watch_frame(input string tag, input logic [7:0] d, input bit big,
                               input bit keep_start, input logic [7:0] next_d,
                               input int poke_cycle, input logic [7:0] poke_d);
        int          n;
        logic [10:0] bits;
        logic        ser, busy, done, rdy;
        logic        e_ser, e_busy, e_done;
        n = big ? 434 : 4;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^d;
`endif
        for (int k = 1; k <= F*n + 1; k++) begin
            @(posedge clk); #1;
            ser  = big ? b_serial     : s_serial;
            busy = big ? bif.tx_busy  : sif.tx_busy;
            done = big ? bif.tx_done  : sif.tx_done;
            rdy  = big ? bif.tx_ready : sif.tx_ready;
            e_ser  = (k <= F*n) ? bits[(k-1)/n] : 1'b1;
            e_busy = (k <= F*n);
            e_done = (k == F*n + 1);
            total++;
            if (ser !== e_ser) begin
                bad++;
                $display("FAIL %s serial k=%0d got=%b exp=%b", tag, k, ser, e_ser);
            end
            total++;
            if (busy !== e_busy) begin
                bad++;
                $display("FAIL %s busy k=%0d got=%b exp=%b", tag, k, busy, e_busy);
            end
            total++;
            if (done !== e_done) begin
                bad++;
                $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, done, e_done);
            end
            total++;
            if (rdy !== !e_busy) begin
                bad++;
                $display("FAIL %s ready k=%0d got=%b exp=%b", tag, k, rdy, !e_busy);
            end
            if (k == 1) begin
                if (keep_start) data = next_d;
                else begin
                    start = 1'b0;
                    data  = ~d;
                end
            end
            if (poke_cycle != 0 && k == poke_cycle) begin
                start = 1'b1;
                data  = poke_d;
            end
            if (poke_cycle != 0 && k == poke_cycle + 1) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++; if (s_serial !== 1'b1)     begin bad++; $display("FAIL rst s_serial got=%b exp=1", s_serial); end
        total++; if (sif.tx_ready !== 1'b1) begin bad++; $display("FAIL rst s_ready got=%b exp=1", sif.tx_ready); end
        total++; if (sif.tx_busy !== 1'b0)  begin bad++; $display("FAIL rst s_busy got=%b exp=0", sif.tx_busy); end
        total++; if (sif.tx_done !== 1'b0)  begin bad++; $display("FAIL rst s_done got=%b exp=0", sif.tx_done); end
        total++; if (b_serial !== 1'b1)     begin bad++; $display("FAIL rst b_serial got=%b exp=1", b_serial); end
        total++; if (bif.tx_ready !== 1'b1) begin bad++; $display("FAIL rst b_ready got=%b exp=1", bif.tx_ready); end
        total++; if (bif.tx_busy !== 1'b0)  begin bad++; $display("FAIL rst b_busy got=%b exp=0", bif.tx_busy); end
        total++; if (bif.tx_done !== 1'b0)  begin bad++; $display("FAIL rst b_done got=%b exp=0", bif.tx_done); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        start = 1'b1;
        data  = 8'hA5;
        watch_frame("single_a5", 8'hA5, 1'b0, 1'b0, 8'h00, 0, 8'h00);
        start = 1'b1;
        data  = 8'h07;
        watch_frame("single_07", 8'h07, 1'b0, 1'b0, 8'h00, 0, 8'h00);
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        data  = 8'h00;
        watch_frame("b2b_00", 8'h00, 1'b0, 1'b1, 8'hFF, 0, 8'h00);
        watch_frame("b2b_ff", 8'hFF, 1'b0, 1'b0, 8'h00, 0, 8'h00);
    endtask

    task automatic test_ignored();
        start = 1'b1;
        data  = 8'h55;
        watch_frame("ignored_55", 8'h55, 1'b0, 1'b0, 8'h00, 10, 8'h3C);
        @(posedge clk); #1;
        total++;
        if (sif.tx_done !== 1'b0) begin bad++; $display("FAIL ignored extra_done got=%b exp=0", sif.tx_done); end
        total++;
        if (sif.tx_ready !== 1'b1) begin bad++; $display("FAIL ignored queued got_ready=%b exp=1", sif.tx_ready); end
        total++;
        if (s_serial !== 1'b1) begin bad++; $display("FAIL ignored line got=%b exp=1", s_serial); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        data  = 8'hA5;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
        end
        reset = 1'b0;
        #1;
        total++; if (s_serial !== 1'b1)     begin bad++; $display("FAIL midrst serial got=%b exp=1", s_serial); end
        total++; if (sif.tx_ready !== 1'b1) begin bad++; $display("FAIL midrst ready got=%b exp=1", sif.tx_ready); end
        total++; if (sif.tx_busy !== 1'b0)  begin bad++; $display("FAIL midrst busy got=%b exp=0", sif.tx_busy); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (sif.tx_done !== 1'b0) begin bad++; $display("FAIL midrst done k=%0d got=%b exp=0", k, sif.tx_done); end
        end
        reset = 1'b1;
        start = 1'b1;
        data  = 8'h81;
        watch_frame("after_rst_81", 8'h81, 1'b0, 1'b0, 8'h00, 0, 8'h00);
    endtask

    task automatic test_default_n();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        start = 1'b1;
        data  = 8'hC3;
        watch_frame("default_c3", 8'hC3, 1'b1, 1'b0, 8'h00, 0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_default_n();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
